// File: rtl/sipo_deserializer.sv
// Purpose: MSB-first serial-to-parallel deserializer with a one-entry valid/ready output register and a sticky overrun flag.
// Latency: out_valid rises on the edge that samples the last bit of a frame (0 cycles after the final sample edge).
// Backpressure: shifting never stalls; a word that completes while the previous word is still held is dropped and flags overflow.
// Optional feature: define SIPO_PARITY_EN to append an even-parity bit to each frame and report parity_err.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  // All WIDTH data bits are held while the parity bit is awaited.
  localparam int SR_W = WIDTH;
  typedef enum logic {COLLECT, PARITY} state_t;
  state_t r_state;
  logic   r_parity_err;
`else
  // The last data bit goes straight into out_data, so only WIDTH-1 bits are stored.
  localparam int SR_W = WIDTH - 1;
`endif

  logic [SR_W-1:0]  r_shift_reg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overflow;

  logic             w_shift;
  logic             w_done;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_word;

  // sync_clr suppresses any strobe on the same edge
  assign w_shift = shift_en && !sync_clr;
  assign w_xfer  = r_out_valid && out_ready;

`ifdef SIPO_PARITY_EN
  assign w_done = w_shift && (r_state == PARITY);
  assign w_word = r_shift_reg;
`else
  assign w_done = w_shift && (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_word = {r_shift_reg, serial_in};
`endif

  // A finished word may load when the slot is empty or drains on this same edge
  assign w_load = w_done && (!r_out_valid || out_ready);

  // Framing: shift register, bit counter and (with parity) the frame state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
`ifdef SIPO_PARITY_EN
      r_state     <= COLLECT;
`endif
    end else if (sync_clr) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
`ifdef SIPO_PARITY_EN
      r_state     <= COLLECT;
`endif
    end else if (shift_en) begin
`ifdef SIPO_PARITY_EN
      if (r_state == COLLECT) begin
        r_shift_reg <= {r_shift_reg[WIDTH-2:0], serial_in};
        r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
        if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
          r_state <= PARITY;
        end
      end else begin
        r_bit_cnt <= '0;
        r_state   <= COLLECT;
      end
`else
      r_shift_reg <= w_word[WIDTH-2:0];
      r_bit_cnt   <= w_done ? '0 : r_bit_cnt + CNT_W'(1);
`endif
    end
  end

  // Output holding register, handshake and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_out_data   <= w_word;
        r_out_valid  <= 1'b1;
`ifdef SIPO_PARITY_EN
        r_parity_err <= (^w_word) ^ serial_in;
`endif
      end else if (w_xfer) begin
        r_out_valid  <= 1'b0;
`ifdef SIPO_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      if (sync_clr) begin
        r_overflow <= 1'b0;
      end else if (w_done && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign bit_cnt   = r_bit_cnt;
  assign overflow  = r_overflow;
`ifdef SIPO_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: vector table, hand-written corner sequences and a randomized run against a frame-level model.
module tb_sipo_deserializer;
  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic         shift_en;
  logic         serial_in;
  logic         sync_clr;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   bit_cnt;
  logic         overflow;
  logic         parity_err;

  int n_checks = 0;
  int n_pass   = 0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
    .sync_clr(sync_clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .bit_cnt(bit_cnt), .overflow(overflow),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: position within the frame, accumulated data value,
  // and the single output slot.
  int m_pos, m_acc, m_data;
  bit m_valid, m_ovf, m_perr;

  task automatic model_edge();
    bit done;
    int word;
    int pbit;
    bit take;
    done = 0; word = 0; pbit = 0;
    if (rst) begin
      m_pos = 0; m_acc = 0; m_data = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    take = m_valid && out_ready;
    if (sync_clr) begin
      m_pos = 0; m_acc = 0; m_ovf = 0;
    end else if (shift_en) begin
      if (m_pos < W) m_acc = (m_acc * 2 + int'(serial_in)) % (1 << W);
      else pbit = int'(serial_in);
      if (m_pos + 1 == FRAME) begin
        done = 1; word = m_acc; m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_data = word; m_valid = 1;
`ifdef SIPO_PARITY_EN
        m_perr = (($countones(word) + pbit) % 2) == 1;
`else
        m_perr = 0;
`endif
      end else begin
        m_ovf = 1;
      end
    end else if (take) begin
      m_valid = 0; m_perr = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive inputs, clock one edge, update the model, settle past the edge.
  task automatic step(input logic r, input logic sh, input logic si, input logic cl, input logic rd);
    rst = r; shift_en = sh; serial_in = si; sync_clr = cl; out_ready = rd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Send one full frame; rd_last is out_ready on the final strobe, bad_par flips the parity bit.
  task automatic send_word(input logic [W-1:0] w, input logic rd, input logic rd_last, input logic bad_par);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, w[W-1-i], 1'b0, (FRAME == W && i == W-1) ? rd_last : rd);
    end
`ifdef SIPO_PARITY_EN
    step(1'b0, 1'b1, (^w) ^ bad_par, 1'b0, rd_last);
`else
    if (bad_par) $display("note: parity ignored in this build");
`endif
  endtask

  typedef struct {
    logic rst, sh, sin, clr, rdy;
    logic ev; logic [W-1:0] ed; logic [3:0] ec; logic eo;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic sh, input logic si, input logic cl, input logic rd,
                     input logic ev, input logic [W-1:0] ed, input logic [3:0] ec, input logic eo);
    vec_t v;
    v.rst = r; v.sh = sh; v.sin = si; v.clr = cl; v.rdy = rd;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endtask

  // Eight strobes of one word; outputs hold their "pre" values until the last bit lands.
  task automatic add_word(input logic [W-1:0] w, input logic rd,
                          input logic ev0, input logic [W-1:0] ed0, input logic eo0,
                          input logic ev1, input logic [W-1:0] ed1, input logic eo1);
    for (int i = 0; i < W-1; i++) add(1'b0, 1'b1, w[W-1-i], 1'b0, rd, ev0, ed0, 4'(i+1), eo0);
    add(1'b0, 1'b1, w[0], 1'b0, rd, ev1, ed1, 4'd0, eo1);
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0; serial_in = 1'b0; sync_clr = 1'b0; out_ready = 1'b0;
    m_pos = 0; m_acc = 0; m_data = 0; m_valid = 0; m_ovf = 0; m_perr = 0;

`ifndef SIPO_PARITY_EN
    // Reset with strobes active, single word with hold, overrun and resync.
    add(1, 1, 1, 0, 0,  0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 0,  0, 8'h00, 0, 0);
    add_word(8'hD5, 0,  0, 8'h00, 0,  1, 8'hD5, 0);
    add(0, 0, 0, 0, 0,  1, 8'hD5, 0, 0);
    add(0, 0, 1, 0, 0,  1, 8'hD5, 0, 0);
    add(0, 0, 0, 0, 1,  0, 8'hD5, 0, 0);
    add_word(8'hA5, 0,  0, 8'hD5, 0,  1, 8'hA5, 0);
    add_word(8'h0F, 0,  1, 8'hA5, 0,  1, 8'hA5, 1);
    add(0, 1, 1, 1, 0,  1, 8'hA5, 0, 0);
    add(0, 0, 0, 0, 1,  0, 8'hA5, 0, 0);
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].sh, tbl[k].sin, tbl[k].clr, tbl[k].rdy);
      chk($sformatf("tbl%0d.valid", k), 32'(out_valid), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d.data", k),  32'(out_data),  32'(tbl[k].ed));
      chk($sformatf("tbl%0d.cnt", k),   32'(bit_cnt),   32'(tbl[k].ec));
      chk($sformatf("tbl%0d.ovf", k),   32'(overflow),  32'(tbl[k].eo));
      chk($sformatf("tbl%0d.perr", k),  32'(parity_err), 32'd0);
    end
`endif

    // Reset state
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.data", 32'(out_data), 0);
    chk("rst.cnt", 32'(bit_cnt), 0);
    chk("rst.ovf", 32'(overflow), 0);

    // Back-to-back words, continuous strobes, downstream always ready
    send_word(8'hD5, 1, 1, 0);
    chk("b2b.first", 32'(out_data), 32'hD5);
    chk("b2b.first_vld", 32'(out_valid), 1);
    send_word(8'h3C, 1, 1, 0);
    chk("b2b.second", 32'(out_data), 32'h3C);
    chk("b2b.ovf", 32'(overflow), 0);
    step(0, 0, 0, 0, 1);
    chk("b2b.drained", 32'(out_valid), 0);

    // Completion on the same edge as the drain of the held word
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h0F, 0, 1, 0);
    chk("drain_load.data", 32'(out_data), 32'h0F);
    chk("drain_load.vld", 32'(out_valid), 1);
    chk("drain_load.ovf", 32'(overflow), 0);
    step(0, 0, 0, 0, 1);

    // Mid-word resync discards the partial word
    for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom_range(0, 1)), 0, 0);
    chk("resync.cnt_pre", 32'(bit_cnt), 5);
    step(0, 0, 0, 1, 0);
    chk("resync.cnt", 32'(bit_cnt), 0);
    chk("resync.novld", 32'(out_valid), 0);
    send_word(8'h81, 0, 0, 0);
    chk("resync.data", 32'(out_data), 32'h81);
    chk("resync.ovf", 32'(overflow), 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    chk("midrst.cnt_pre", 32'(bit_cnt), 3);
    step(1, 0, 0, 0, 0);
    chk("midrst.cnt", 32'(bit_cnt), 0);

`ifdef SIPO_PARITY_EN
    // Parity: correct bit, flipped bit, clear on transfer
    step(0, 0, 0, 0, 0);
    send_word(8'hD5, 0, 0, 0);
    chk("par.ok", 32'(parity_err), 0);
    chk("par.ok_data", 32'(out_data), 32'hD5);
    step(0, 0, 0, 0, 1);
    send_word(8'hD5, 0, 0, 1);
    chk("par.bad", 32'(parity_err), 1);
    step(0, 0, 0, 0, 1);
    chk("par.cleared", 32'(parity_err), 0);
`endif

    // Randomized run against the model
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4));
      chk("rnd.valid", 32'(out_valid), 32'(m_valid));
      chk("rnd.data", 32'(out_data), 32'(m_data));
      chk("rnd.cnt", 32'(bit_cnt), 32'(m_pos));
      chk("rnd.ovf", 32'(overflow), 32'(m_ovf));
      chk("rnd.perr", 32'(parity_err), 32'(m_perr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
